// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared state type, dimension limits and max helpers for the maxpool1 stage.
// The helpers work at MAX_W bits; callers extend operands and truncate the result.
package maxpool_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int MAX_W      = 32;
  localparam int MIN_DIM    = 2;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } pool_state_t;

  function automatic bit dim_legal(input int d);
    return (d >= MIN_DIM) && (d % 2 == 0);
  endfunction

  function automatic logic [MAX_W-1:0] max_u(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  function automatic logic signed [MAX_W-1:0] max_s(input logic signed [MAX_W-1:0] a,
                                                    input logic signed [MAX_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_channel.sv
// pool_channel: ReLU, horizontal pair max, line buffer and vertical max for one channel.
// RELU_EN defined: ReLU then unsigned compare; undefined: signed compare, no ReLU.
module pool_channel
  import maxpool_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LB_DEPTH = 12,
  parameter int LB_AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_h,
  input  logic              write_lb,
  input  logic              emit,
  input  logic [LB_AW-1:0]  lb_addr,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] pool_out
);

  logic [DATA_W-1:0] x_r;
  logic [DATA_W-1:0] h_reg;
  logic [DATA_W-1:0] hmax;
  logic [DATA_W-1:0] vmax;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] lb [LB_DEPTH];

  assign lb_rd = lb[lb_addr];

`ifdef RELU_EN
  assign x_r  = x[DATA_W-1] ? '0 : x;
  assign hmax = DATA_W'(max_u(MAX_W'(h_reg), MAX_W'(x_r)));
  assign vmax = DATA_W'(max_u(MAX_W'(lb_rd), MAX_W'(hmax)));
`else
  assign x_r  = x;
  assign hmax = DATA_W'(max_s(MAX_W'($signed(h_reg)), MAX_W'($signed(x_r))));
  assign vmax = DATA_W'(max_s(MAX_W'($signed(lb_rd)), MAX_W'($signed(hmax))));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg    <= '0;
      pool_out <= '0;
    end else begin
      if (load_h) h_reg <= x_r;
      if (emit)   pool_out <= vmax;
    end
  end

  // Line buffer is always written on an even row before the odd row reads it, so no reset.
  always_ff @(posedge clk) begin
    if (write_lb) lb[lb_addr] <= hmax;
  end

endmodule

// File: rtl/maxpool1_layer.sv
// maxpool1_layer: ReLU + 2x2/stride-2 max pooling of three conv1 channels, raster input.
// Optional RELU_EN macro enables ReLU with unsigned compares (see pool_channel).
module maxpool1_layer
  import maxpool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IN_W   = 24,
  parameter int IN_H   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] conv_in_1,
  input  logic [DATA_W-1:0] conv_in_2,
  input  logic [DATA_W-1:0] conv_in_3,
  input  logic              valid_in,
  output logic [DATA_W-1:0] pool_out_1,
  output logic [DATA_W-1:0] pool_out_2,
  output logic [DATA_W-1:0] pool_out_3,
  output logic              valid_out_pool,
  output logic              frame_done
);

  localparam int CW       = $clog2(IN_W);
  localparam int RW       = $clog2(IN_H);
  localparam int LB_DEPTH = IN_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  if (!dim_legal(IN_W) || !dim_legal(IN_H)) begin : g_bad_dims
    $error("maxpool1_layer: IN_W and IN_H must be even and >= 2");
  end
  if (DATA_W > MAX_W) begin : g_bad_width
    $error("maxpool1_layer: DATA_W exceeds compare helper width");
  end

  pool_state_t      state, state_nxt;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [LB_AW-1:0] lb_addr;
  logic             col_last, row_last;
  logic             load_h, write_lb, emit, last_win;

  assign col_last = (col == CW'(IN_W - 1));
  assign row_last = (row == RW'(IN_H - 1));
  assign lb_addr  = LB_AW'(col >> 1);

  // FSM tracks row parity: FILL on even rows, EMIT on odd rows.
  always_comb begin
    state_nxt = state;
    load_h    = 1'b0;
    write_lb  = 1'b0;
    emit      = 1'b0;
    last_win  = 1'b0;
    if (valid_in && !rst) begin
      load_h   = ~col[0];
      write_lb = col[0] && (state == FILL);
      emit     = col[0] && (state == EMIT);
      last_win = col[0] && (state == EMIT) && col_last && row_last;
      if (col_last) state_nxt = (state == FILL) ? EMIT : FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL;
      col            <= '0;
      row            <= '0;
      valid_out_pool <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_nxt;
      valid_out_pool <= emit;
      frame_done     <= last_win;
      if (valid_in) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  pool_channel #(.DATA_W(DATA_W), .LB_DEPTH(LB_DEPTH), .LB_AW(LB_AW)) u_ch1 (
    .clk(clk), .rst(rst), .load_h(load_h), .write_lb(write_lb), .emit(emit),
    .lb_addr(lb_addr), .x(conv_in_1), .pool_out(pool_out_1)
  );

  pool_channel #(.DATA_W(DATA_W), .LB_DEPTH(LB_DEPTH), .LB_AW(LB_AW)) u_ch2 (
    .clk(clk), .rst(rst), .load_h(load_h), .write_lb(write_lb), .emit(emit),
    .lb_addr(lb_addr), .x(conv_in_2), .pool_out(pool_out_2)
  );

  pool_channel #(.DATA_W(DATA_W), .LB_DEPTH(LB_DEPTH), .LB_AW(LB_AW)) u_ch3 (
    .clk(clk), .rst(rst), .load_h(load_h), .write_lb(write_lb), .emit(emit),
    .lb_addr(lb_addr), .x(conv_in_3), .pool_out(pool_out_3)
  );

endmodule
